shift_unit_seq: RTL and testbench

Parametrised sequential shift/rotate unit. It is the clocked successor to the fixed 8-bit shift-left-by-one buffer stage.
- Loads a WIDTH-bit operand on a start handshake.
- Shifts or rotates it one bit position per clock for a programmable number of steps.
- Reports the last bit shifted out on cout.
- Sits between the datapath operand registers and the result bus. Raises done when the result is valid.

---
 rtl/shift_unit_seq.sv | 83 ++++++++
 tb/tb_shift_unit_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: loads an operand on start, then applies one
// shift or rotate step per clock for a programmed number of steps.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       mode_r;
  logic             accept;
  logic [WIDTH:0]   step_res;

  // One step of the selected operation; result is {cout, f}.
  // Reserved modes hold both f and cout.
  function automatic logic [WIDTH:0] step_op(input logic [2:0] op,
                                             input logic [WIDTH-1:0] v,
                                             input logic c);
    case (op)
      3'b000:  step_op = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      3'b001:  step_op = {v[0], 1'b0, v[WIDTH-1:1]};
      3'b010:  step_op = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      3'b011:  step_op = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  step_op = {v[0], v[0], v[WIDTH-1:1]};
      default: step_op = {c, v};
    endcase
  endfunction

  assign accept   = start && (state != SHIFT);
  assign step_res = step_op(mode_r, f, cout);
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (amt == '0) ? DONE : SHIFT;
    end else begin
      case (state)
        SHIFT:   if (cnt == AMT_W'(1)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath: load on accepted start, step while shifting, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f      <= '0;
      cout   <= 1'b0;
      cnt    <= '0;
      mode_r <= 3'b000;
    end else if (accept) begin
      f      <= x;
      cout   <= 1'b0;
      cnt    <= amt;
      mode_r <= mode;
    end else if (state == SHIFT) begin
      {cout, f} <= step_res;
      cnt       <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: a driver issues starts and queues the
// expected result and timing; a monitor checks done/busy/f/cout every cycle.
module tb_shift_unit_seq;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  x;
  logic [W-1:0]  f;
  logic          cout, busy, done;

  shift_unit_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt), .x(x),
    .f(f), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] f;
    logic         c;
    int           start_cyc;
    int           done_cyc;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_start = -1;
  int    last_done  = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: apply n single-bit steps using plain integer arithmetic.
  function automatic logic [W:0] ref_run(input logic [W-1:0] xv, input logic [2:0] m, input int n);
    int v, c, top, full, s;
    v = int'(xv); c = 0; top = 1 << (W-1); full = 1 << W;
    for (int i = 0; i < n; i++) begin
      case (m)
        3'd0: begin c = v / top; v = (v * 2) % full; end
        3'd1: begin c = v % 2; v = v / 2; end
        3'd2: begin s = (v >= top) ? top : 0; c = v % 2; v = v / 2 + s; end
        3'd3: begin c = v / top; v = (v * 2) % full + c; end
        3'd4: begin c = v % 2; v = v / 2 + c * top; end
        default: ;
      endcase
    end
    return {1'(c), W'(v)};
  endfunction

  // Called right after a falling edge; the next rising edge is edge 0.
  task automatic issue(input logic [W-1:0] xv, input logic [2:0] m, input int a, input bit trace);
    int    cur;
    item_t it;
    logic [W:0] r;
    cur = cyc;
    x = xv; mode = m; amt = AW'(a); start = 1'b1;
    if (!(last_start <= cur && cur < last_done)) begin
      r = ref_run(xv, m, a);
      it.f = r[W-1:0]; it.c = r[W];
      it.start_cyc = cur + 1; it.done_cyc = cur + 1 + a;
      last_start = it.start_cyc; last_done = it.done_cyc;
      q.push_back(it);
    end
    @(negedge clk);
    start = 1'b0;
    if (trace) begin
      for (int j = 0; j <= a; j++) begin
        if (j > 0) @(negedge clk);
        r = ref_run(xv, m, j);
        chk($sformatf("trace_f_step%0d", j), 32'(f), 32'(r[W-1:0]));
        chk($sformatf("trace_cout_step%0d", j), 32'(cout), 32'(r[W]));
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL wait_idle_timeout actual=%0d pending required=0", q.size());
      q.delete();
    end
  endtask

  // Monitor: done and busy must match the scheduled window of the oldest
  // pending operation; result checked when done is presented.
  always @(negedge clk) begin
    bit    exp_done, exp_busy;
    item_t it;
    if (!rst) begin
      exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
      exp_busy = (q.size() > 0) && (cyc >= q[0].start_cyc) && (cyc < q[0].done_cyc);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
        it = q.pop_front();
        if (done) begin
          chk("result_f", 32'(f), 32'(it.f));
          chk("result_cout", 32'(cout), 32'(it.c));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'd0; amt = '0; x = '0;
    repeat (2) @(negedge clk);
    chk("reset_f", 32'(f), 32'h0);
    chk("reset_cout", 32'(cout), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of an LSR after two steps.
    issue(8'hFF, 3'd1, 5, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_f", 32'(f), 32'h0);
    chk("midrst_cout", 32'(cout), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    q.delete(); last_start = -1; last_done = -1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(negedge clk);

    // Legacy-equivalent LSL by one.
    issue(8'h81, 3'd0, 1, 1'b0); wait_idle();
    chk("lsl81_f", 32'(f), 32'h02);
    chk("lsl81_cout", 32'(cout), 32'h1);
    @(negedge clk);
    issue(8'h01, 3'd0, 1, 1'b0); wait_idle();
    chk("lsl01_f", 32'(f), 32'h02);
    chk("lsl01_cout", 32'(cout), 32'h0);

    // ASR and ROR with every intermediate step checked.
    @(negedge clk);
    issue(8'h90, 3'd2, 3, 1'b1); wait_idle();
    chk("asr_f", 32'(f), 32'hF2);
    chk("asr_cout", 32'(cout), 32'h0);
    @(negedge clk);
    issue(8'hA5, 3'd4, 4, 1'b1); wait_idle();
    chk("ror_f", 32'(f), 32'h5A);
    chk("ror_cout", 32'(cout), 32'h0);

    // Long LSR beyond WIDTH, with a start at edge 4 that must be ignored.
    @(negedge clk);
    issue(8'hFF, 3'd1, 12, 1'b0);
    repeat (3) @(negedge clk);
    issue(8'hAA, 3'd0, 1, 1'b0);
    wait_idle();
    chk("lsr12_f", 32'(f), 32'h00);
    chk("lsr12_cout", 32'(cout), 32'h0);

    // amt=0, then a back-to-back start in DONE with a reserved mode.
    @(negedge clk);
    issue(8'h3C, 3'd3, 0, 1'b0);
    chk("amt0_f", 32'(f), 32'h3C);
    chk("amt0_cout", 32'(cout), 32'h0);
    issue(8'h5B, 3'd6, 2, 1'b0);
    wait_idle();
    chk("rsvd_f", 32'(f), 32'h5B);
    chk("rsvd_cout", 32'(cout), 32'h0);

    // Randomized traffic, including starts that land while shifting.
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      issue(W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 15), 1'b0);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
